// File: rtl/dot_product_scheduler.sv
// ---------------------------------------------------------------------------
// dot_product_scheduler
//
// Time-shares a single 4-element dot-product engine between NUM_REQ
// requesters. A round-robin arbiter picks one pending requester, latches its
// operands onto the engine bus and releases the engine's restart. When the
// engine reports a valid result, the scheduler returns it to the granted
// requester as a one-cycle response. If the engine stays silent for TIMEOUT
// cycles, an error response is returned instead.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   req        per-requester request, held with operands until granted
//   req_a      operands a, element k of requester i at [(i*4+k)*W +: W]
//   req_b      operands b, same packing as req_a
//   grant      one-hot grant (combinational, IDLE only)
//   resp_v     one-hot, one-cycle response strobe to the served requester
//   resp_data  signed 2W-bit result, held until the next response
//   resp_err   set with resp_v when the response came from a timeout
//   busy       high while an operation is in flight
//   dp_a/dp_b  latched operands to the engine, element k at [k*W +: W]
//   dp_rst     registered engine restart; high holds the engine idle
//   dp_out     engine result
//   dp_out_v   engine result valid
// ---------------------------------------------------------------------------
module dot_product_scheduler #(
  parameter int W       = 16,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*4*W-1:0] req_a,
  input  logic [NUM_REQ*4*W-1:0] req_b,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     resp_v,
  output logic [2*W-1:0]         resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic [4*W-1:0]         dp_a,
  output logic [4*W-1:0]         dp_b,
  output logic                   dp_rst,
  input  logic [2*W-1:0]         dp_out,
  input  logic                   dp_out_v
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     winner_idx_q, winner_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*W-1:0]       dp_a_q, dp_a_d;
  logic [4*W-1:0]       dp_b_q, dp_b_d;
  logic                 dp_rst_q, dp_rst_d;
  logic [NUM_REQ-1:0]   resp_v_q, resp_v_d;
  logic [2*W-1:0]       resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;

  // Round-robin search results
  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic [NUM_REQ-1:0]   winner_onehot;
  logic [NUM_REQ-1:0]   served_onehot;
  logic [4*W-1:0]       sel_a;
  logic [4*W-1:0]       sel_b;

  // Search for the first pending request starting at ptr and wrapping to 0.
  // The candidate index is reduced modulo NUM_REQ so non-power-of-two
  // requester counts never select a nonexistent slot.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Decode the winner and the served requester to one-hot vectors, and mux
  // out the winner's operand block with constant part-selects.
  always_comb begin
    winner_onehot = '0;
    served_onehot = '0;
    sel_a         = '0;
    sel_b         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        winner_onehot[i] = 1'b1;
        sel_a            = req_a[i*4*W +: 4*W];
        sel_b            = req_b[i*4*W +: 4*W];
      end
      if (winner_idx_q == IDX_W'(i)) begin
        served_onehot[i] = 1'b1;
      end
    end
  end

  // Grant only exists in IDLE and is suppressed while reset is asserted so a
  // requester never believes it was served by an edge that reset discards.
  always_comb begin
    grant = '0;
    if (state_q == IDLE && !rst && found) begin
      grant = winner_onehot;
    end
  end

  // Next-state and datapath update. Everything holds by default except the
  // response strobe, which is a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    winner_idx_d = winner_idx_q;
    cnt_d        = cnt_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_rst_d     = dp_rst_q;
    resp_v_d     = '0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        dp_rst_d = 1'b1;
        if (found) begin
          dp_a_d       = sel_a;
          dp_b_d       = sel_b;
          winner_idx_d = winner;
          ptr_d        = (winner == IDX_LAST) ? '0 : winner + IDX_W'(1);
          dp_rst_d     = 1'b0;
          cnt_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A real result wins over a timeout landing in the same cycle.
        if (dp_out_v) begin
          resp_data_d = dp_out;
          resp_err_d  = 1'b0;
          resp_v_d    = served_onehot;
          dp_rst_d    = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          resp_v_d    = served_onehot;
          dp_rst_d    = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        dp_rst_d = 1'b1;
      end
    endcase
  end

  // State register. Reset discards any in-flight operation without a
  // response and parks the engine in restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      winner_idx_q <= '0;
      cnt_q        <= '0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_rst_q     <= 1'b1;
      resp_v_q     <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      winner_idx_q <= winner_idx_d;
      cnt_q        <= cnt_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_rst_q     <= dp_rst_d;
      resp_v_q     <= resp_v_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_rst    = dp_rst_q;
  assign resp_v    = resp_v_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule

// File: doc/dot_product_scheduler.md
Name: dot_product_scheduler

Overview:
- Time-shares one 4-element dot_product engine between NUM_REQ requesters.
- Round-robin arbitration picks one requester, latches its operands and drives the engine's restart input.
- Waits for the engine's valid output, then returns the 2W-bit result to the granted requester as a one-cycle response.
- Sits between the per-layer convolution units and the single shared multiplier datapath.

Parameters:
- W, 16, operand width; results are 2*W bits.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum RUN cycles to wait for dp_out_v before an error response.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester request; held with operands until granted.
- req_a  in  NUM_REQ*4*W  operands a; element k of requester i at bits [(i*4+k)*W +: W], signed.
- req_b  in  NUM_REQ*4*W  operands b; same packing as req_a.
- grant  out  NUM_REQ  one-hot, combinational; operands of the granted requester are captured on this edge.
- resp_v  out  NUM_REQ  one-hot, registered, one-cycle response strobe to the served requester.
- resp_data  out  2*W  signed result; valid while resp_v is nonzero.
- resp_err  out  1  high with resp_v when the response was caused by a timeout.
- busy  out  1  high while not IDLE.
- dp_a  out  4*W  latched a operands to the engine; element k at [k*W +: W].
- dp_b  out  4*W  latched b operands to the engine.
- dp_rst  out  1  registered restart to the engine; high holds the engine idle.
- dp_out  in  2*W  engine result.
- dp_out_v  in  1  engine result valid.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, ptr=0, dp_rst=1.
  - resp_v=0, resp_data=0, resp_err=0, dp_a/dp_b=0, cnt=0.
  - grant forced 0 while rst is high.
  - Any in-flight operation is discarded with no response.
  - rst dominates all simultaneous events.
- States: IDLE, RUN.
- IDLE:
  - dp_rst=1.
  - If req is nonzero, the winner is the first set bit searching from ptr upward with wrap to 0.
  - grant=onehot(winner) combinationally, only in this state.
  - At the edge: capture the winner's operands into dp_a/dp_b, winner_idx<=winner, ptr<=(winner+1) mod NUM_REQ, dp_rst<=0, cnt<=0, go to RUN.
  - If no request, stay in IDLE; grant=0.
- RUN:
  - grant=0 and cnt increments every cycle.
  - Requests arriving during RUN stay pending; requesters must hold req and operands.
  - If dp_out_v=1: resp_data<=dp_out, resp_err<=0, resp_v<=onehot(winner_idx), dp_rst<=1, go to IDLE.
  - Else if cnt==TIMEOUT-1: resp_data<=0, resp_err<=1, resp_v<=onehot(winner_idx), dp_rst<=1, go to IDLE.
  - dp_out_v has priority over timeout in the same cycle.
- Response:
  - resp_v is high for exactly one cycle; it returns to 0 on the next edge unless another response fires.
  - resp_data and resp_err hold their value until the next response.
- Latency with the standard engine (5 edges from restart release to out_v):
  - Grant in cycle T; dp_rst low in cycles T+1..T+6.
  - dp_out_v seen in cycle T+6.
  - resp_v high in cycle T+7, with state back in IDLE.
  - A new grant is possible in T+7; dp_rst is high for at least one full cycle between operations.
  - Throughput: one operation per 7 cycles.
- The requester sees grant and must drop req, or present its next operation, by the following IDLE cycle.
- An un-dropped req is treated as a new request.
- Arithmetic is done entirely by the engine; the scheduler never modifies data.
- busy = (state==RUN).

Test Plan:
- Single request: req=0001, a={1,2,3,4}, b={5,6,7,8}; grant=0001 in T, resp_v=0001 with resp_data=70 in T+7, resp_err=0, busy high in T+1..T+6.
- Signed operands: requester 2, a={-3,2,0,1}, b={4,-5,7,100}; resp_data=78 on resp_v=0100.
- Contention: req=1111 all held from cycle 0, each drops after its grant; grants occur in order 0,1,2,3 at 7-cycle spacing, each response carries its own operands' result, and ptr wraps to 0.
- Fairness: req0 and req2 asserted continuously; grants alternate 0,2,0,2 and never 0,0.
- Timeout: engine model never raises dp_out_v; resp_v pulses with resp_err=1 and resp_data=0 exactly TIMEOUT cycles after entering RUN. A following normal request then completes correctly.
- Reset mid-operation: rst asserted in T+3 for one cycle; no resp_v is produced, dp_rst=1, ptr=0, and the next request is granted to the lowest-index requester.
